multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It replaces the single-cycle control unit so that instruction fetch and data access share one memory port. It steps the existing PC, register file, ALU and ALU-operand mux through fetch, decode, execute, memory and write-back. It drives a one-port memory through a request/ready handshake.

## Interface
- `DATA_W`, 32: datapath width, used only for the performance counters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `instr`  in  32  current instruction register contents; valid from DECODE onward.
- `EQ`  in  1  ALU equality flag, sampled in EXECUTE.
- `mem_ready`  in  1  memory accepts or completes the access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write enable; 1 = store.
- `addr_src`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `IRWrite`  out  1  load `instr` register.
- `PCWrite`  out  1  update PC.
- `PCsrc`  out  1  PC source: 0 = PC+4, 1 = oldPC+ImmOp.
- `RegWrite`  out  1  register file write enable.
- `result_src`  out  1  write-back source: 0 = ALU, 1 = memory data.
- `ALUsrc`  out  1  ALU operand 2 select: 0 = register, 1 = immediate.
- `ALUctrl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc`  out  2  immediate format: 00 I, 01 S, 10 B.
- `illegal`  out  1  unsupported opcode trapped.
- `cycle_cnt`, `instret_cnt`  out  `DATA_W` each  present only under the configuration macro.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- Supported opcodes: 0110011 R (add/sub/and/or/slt), 0010011 addi, 0000011 lw, 0100011 sw, 1100011 bne. R-type add vs sub is selected by funct7[5].
- FETCH: `mem_req`=1, `addr_src`=0, `mem_we`=0. In the cycle `mem_ready`=1: assert `IRWrite`=1 and `PCWrite`=1 with `PCsrc`=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. A supported opcode goes to EXECUTE; any other opcode goes to TRAP.
- EXECUTE:
  - R-type and addi go to WB.
  - lw and sw go to MEM. `ALUctrl`=add, `ALUsrc`=1.
  - bne: `ALUctrl`=sub. If `EQ`=0, assert `PCWrite`=1 and `PCsrc`=1. Go to FETCH.
- MEM: `mem_req`=1, `addr_src`=1, `mem_we` set for sw. Hold until `mem_ready`=1, then lw goes to WB and sw goes to FETCH.
- WB: `RegWrite`=1 for one cycle, `result_src`=1 only for lw. Go to FETCH.
- TRAP: `illegal`=1. All enables stay 0. The block stays in TRAP until reset.
- Control outputs are decoded from the state and `instr`. `IRWrite` and PCWrite-in-FETCH also depend on `mem_ready`.

## Timing
- Reset (`rst`=0 at an edge) puts the block in FETCH. Every enable output goes to 0, `ALUctrl`=000, `ImmSrc`=00 and `illegal`=0. In FETCH `mem_req` rises in the first cycle after reset release.
- Reset mid-transaction: `mem_req` drops in the cycle reset is applied. No PC or register write occurs.
- Handshake:
  - Once `mem_req` is high, `mem_req`, `addr_src` and `mem_we` stay stable until `mem_ready` is sampled high.
  - A transfer completes on the edge where `mem_req` and `mem_ready` are both 1.
  - `mem_ready` is ignored while `mem_req`=0.
- Latency with zero-wait memory: R-type/addi 4, lw 5, sw 4, bne 3 cycles. Each memory wait cycle adds one.
- At most one of `RegWrite`, `mem_we`, `PCWrite` is asserted per cycle, except FETCH (`IRWrite` with `PCWrite`).

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined:
  - `cycle_cnt` increments every cycle out of reset.
  - `instret_cnt` increments on each exit to FETCH from WB, from MEM (sw) or from EXECUTE (bne).
  - Both reset to 0, wrap modulo 2^`DATA_W`, and freeze in TRAP.
- Not defined: both ports and their logic are absent.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - opcode localparams;
  - `ALUctrl` and `ImmSrc` encodings;
  - the instruction-class enum (ALU_R, ALU_I, LOAD, STORE, BRANCH, ILLEGAL).
- Sub-module `ctrl_decoder` is combinational: opcode/funct3/funct7 in; class, `ALUctrl` and `ImmSrc` out. The FSM lives in `multicycle_ctrl`.

## Test plan
- Reset held low for 3 cycles with `mem_ready`=1 → all outputs 0. First `mem_req`=1, `addr_src`=0 in the cycle after release.
- addi x10,x0,5 (0x00500513), zero-wait memory → `IRWrite` at cycle 0, `ALUsrc`=1 and `ALUctrl`=000 at cycle 2, `RegWrite`=1 at cycle 3, back in FETCH at cycle 4.
- lw with `mem_ready` delayed 3 cycles in MEM → `mem_req`, `addr_src`=1, `mem_we`=0 stable for 4 cycles. Then one `RegWrite` cycle with `result_src`=1.
- bne with `EQ`=0 → `PCWrite`=1 and `PCsrc`=1 in EXECUTE. With `EQ`=1 → `PCWrite`=0. Next state FETCH in both cases.
- Opcode 0x7F → `illegal`=1 from the cycle after DECODE, no enables asserted, held until `rst`=0.
- Under `MULTICYCLE_CTRL_PERF_EN`: run addi, sw, bne back-to-back → `instret_cnt`=3, `cycle_cnt`=11 (zero-wait). Reset mid-MEM → both counters 0 and `mem_req` low on the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared types and encodings for the multi-cycle RV32I sequencer:
//            FSM states, instruction classes, opcodes, ALU and immediate
//            select encodings.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      TRAP    = 3'd5
   } state_t;

   // Instruction classes produced by the decoder
   typedef enum logic [2:0] {
      ALU_R   = 3'd0,
      ALU_I   = 3'd1,
      LOAD    = 3'd2,
      STORE   = 3'd3,
      BRANCH  = 3'd4,
      ILLEGAL = 3'd5
   } instr_class_t;

   // Supported major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ALU operation encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Immediate format encodings
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decoder
// Brief    : Combinational instruction decoder. Maps opcode/funct3/funct7 to
//            an instruction class, ALU operation and immediate format.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decoder
   import ctrl_pkg::*;
(
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [6:0]   funct7,
   output instr_class_t iclass,
   output logic [2:0]   alu_ctrl,
   output logic [1:0]   imm_src
);

   // Only funct7[5] distinguishes add from sub among the supported ops
   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   // Classify the instruction and pick its ALU operation and immediate type
   always_comb begin
      iclass   = ILLEGAL;
      alu_ctrl = ALU_ADD;
      imm_src  = IMM_I;
      case (opcode)
         OP_R: begin
            iclass = ALU_R;
            case (funct3)
               3'b000:  alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
               3'b111:  alu_ctrl = ALU_AND;
               3'b110:  alu_ctrl = ALU_OR;
               3'b010:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         OP_I:      iclass = ALU_I;
         OP_LOAD:   iclass = LOAD;
         OP_STORE: begin
            iclass  = STORE;
            imm_src = IMM_S;
         end
         OP_BRANCH: begin
            iclass   = BRANCH;
            alu_ctrl = ALU_SUB;
            imm_src  = IMM_B;
         end
         default:   iclass = ILLEGAL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle RV32I sequencer (FETCH/DECODE/EXECUTE/MEM/WB/TRAP)
//            sharing one memory port through a req/ready handshake.
//            Optional performance counters under MULTICYCLE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic              EQ,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic              addr_src,
   output logic              IRWrite,
   output logic              PCWrite,
   output logic              PCsrc,
   output logic              RegWrite,
   output logic              result_src,
   output logic              ALUsrc,
   output logic [2:0]        ALUctrl,
   output logic [1:0]        ImmSrc,
   output logic              illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [DATA_W-1:0] cycle_cnt,
   output logic [DATA_W-1:0] instret_cnt
`endif
);

   state_t       state_q, state_d;
   instr_class_t dec_class;
   logic [2:0]   dec_alu;
   logic [1:0]   dec_imm;
   logic         uses_imm;

   // Register-index and rd fields belong to the datapath, not the sequencer
   logic unused_instr;
   assign unused_instr = ^{instr[24:15], instr[11:7]};

   ctrl_decoder u_decoder (
      .opcode   (instr[6:0]),
      .funct3   (instr[14:12]),
      .funct7   (instr[31:25]),
      .iclass   (dec_class),
      .alu_ctrl (dec_alu),
      .imm_src  (dec_imm)
   );

   assign uses_imm = (dec_class == ALU_I) || (dec_class == LOAD) || (dec_class == STORE);

   // Next state and control outputs from state, instruction and handshake;
   // reset forces every output low at once so no write can land during it
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_src   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCsrc      = 1'b0;
      RegWrite   = 1'b0;
      result_src = 1'b0;
      ALUsrc     = 1'b0;
      ALUctrl    = ALU_ADD;
      ImmSrc     = IMM_I;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            ImmSrc  = dec_imm;
            state_d = (dec_class == ILLEGAL) ? TRAP : EXECUTE;
         end
         EXECUTE: begin
            ImmSrc  = dec_imm;
            ALUctrl = dec_alu;
            ALUsrc  = uses_imm;
            case (dec_class)
               ALU_R, ALU_I: state_d = WB;
               LOAD, STORE:  state_d = MEM;
               BRANCH: begin
                  if (!EQ) begin
                     PCWrite = 1'b1;
                     PCsrc   = 1'b1;
                  end
                  state_d = FETCH;
               end
               default:      state_d = TRAP;
            endcase
         end
         MEM: begin
            // Operands held so the ALU address stays valid across waits
            ImmSrc   = dec_imm;
            ALUctrl  = dec_alu;
            ALUsrc   = 1'b1;
            mem_req  = 1'b1;
            addr_src = 1'b1;
            mem_we   = (dec_class == STORE);
            if (mem_ready) begin
               state_d = (dec_class == STORE) ? FETCH : WB;
            end
         end
         WB: begin
            ImmSrc     = dec_imm;
            ALUctrl    = dec_alu;
            ALUsrc     = uses_imm;
            RegWrite   = 1'b1;
            result_src = (dec_class == LOAD);
            state_d    = FETCH;
         end
         TRAP:    illegal = 1'b1;
         default: state_d = FETCH;
      endcase
      if (!rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         addr_src   = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         PCsrc      = 1'b0;
         RegWrite   = 1'b0;
         result_src = 1'b0;
         ALUsrc     = 1'b0;
         ALUctrl    = ALU_ADD;
         ImmSrc     = IMM_I;
         illegal    = 1'b0;
      end
   end

   // State register with synchronous active-low reset into FETCH
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [DATA_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [DATA_W-1:0] instret_cnt_q, instret_cnt_d;
   logic              retire;

   // Count cycles and retirements; both freeze once trapped
   always_comb begin
      retire = (state_q == WB) ||
               ((state_q == MEM) && (dec_class == STORE) && mem_ready) ||
               ((state_q == EXECUTE) && (dec_class == BRANCH));
      cycle_cnt_d   = cycle_cnt_q;
      instret_cnt_d = instret_cnt_q;
      if (state_q != TRAP) begin
         cycle_cnt_d = cycle_cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
         if (retire) begin
            instret_cnt_d = instret_cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`else
   logic [DATA_W-1:0] unused_perf_w;
   assign unused_perf_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl. Outputs are
//            packed into one vector and compared against hand-computed values
//            half a clock after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        EQ;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_src, IRWrite, PCWrite, PCsrc;
   logic        RegWrite, result_src, ALUsrc, illegal;
   logic [2:0]  ALUctrl;
   logic [1:0]  ImmSrc;
`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Packed output bit positions
   localparam logic [14:0] MREQ = 15'h4000;
   localparam logic [14:0] MWE  = 15'h2000;
   localparam logic [14:0] ASRC = 15'h1000;
   localparam logic [14:0] IRW  = 15'h0800;
   localparam logic [14:0] PCW  = 15'h0400;
   localparam logic [14:0] PCS  = 15'h0200;
   localparam logic [14:0] RW   = 15'h0100;
   localparam logic [14:0] RS   = 15'h0080;
   localparam logic [14:0] ASR  = 15'h0040;
   localparam logic [14:0] SUB  = 15'h0008;   // ALUctrl 001
   localparam logic [14:0] OR3  = 15'h0018;   // ALUctrl 011
   localparam logic [14:0] SLT  = 15'h0028;   // ALUctrl 101
   localparam logic [14:0] IMMS = 15'h0002;   // ImmSrc 01
   localparam logic [14:0] IMMB = 15'h0004;   // ImmSrc 10
   localparam logic [14:0] ILL  = 15'h0001;
   localparam logic [14:0] M_ALL = 15'h7FFF;
   localparam logic [14:0] M_EN  = 15'h7F81;  // enables + illegal only

   // Instruction words
   localparam logic [31:0] I_ADDI = 32'h00500513;  // addi x10,x0,5
   localparam logic [31:0] I_LW   = 32'h0080A283;  // lw   x5,8(x1)
   localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2,4(x1)
   localparam logic [31:0] I_BNE  = 32'h00209463;  // bne  x1,x2,8
   localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
   localparam logic [31:0] I_OR   = 32'h0020E1B3;  // or   x3,x1,x2
   localparam logic [31:0] I_SLT  = 32'h0020A1B3;  // slt  x3,x1,x2
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   logic [14:0] outs;
   assign outs = {mem_req, mem_we, addr_src, IRWrite, PCWrite, PCsrc,
                  RegWrite, result_src, ALUsrc, ALUctrl, ImmSrc, illegal};

   multicycle_ctrl #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .EQ         (EQ),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_src   (addr_src),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .PCsrc      (PCsrc),
      .RegWrite   (RegWrite),
      .result_src (result_src),
      .ALUsrc     (ALUsrc),
      .ALUctrl    (ALUctrl),
      .ImmSrc     (ImmSrc),
      .illegal    (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after a falling edge, check, then advance
   task automatic cyc(input logic [31:0] ins, input logic eq, input logic rdy,
                      input logic [14:0] mask, input logic [14:0] exp, input string tag);
      instr     = ins;
      EQ        = eq;
      mem_ready = rdy;
      #1;
      chk(tag, {17'd0, outs & mask}, {17'd0, exp});
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; instr = 32'd0; EQ = 1'b0; mem_ready = 1'b1;

      // Reset held for 3 cycles with mem_ready high: everything low
      repeat (3) begin
         @(negedge clk); #1;
         chk("reset_outs", {17'd0, outs}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
         chk("reset_cyc", cycle_cnt, 32'd0);
         chk("reset_ret", instret_cnt, 32'd0);
`endif
      end
      @(negedge clk);
      rst = 1'b1;

      // addi, zero-wait
      cyc(I_ADDI, 0, 1, M_ALL, MREQ | IRW | PCW, "addi_fetch");
      cyc(I_ADDI, 0, 1, M_EN,  15'h0,            "addi_decode");
      cyc(I_ADDI, 0, 1, M_ALL, ASR,              "addi_exec");
      cyc(I_ADDI, 0, 1, M_EN,  RW,               "addi_wb");
      // back in FETCH, memory not ready yet
      cyc(I_LW,   0, 0, M_ALL, MREQ,             "fetch_wait");

      // lw with 3 wait cycles in MEM
      cyc(I_LW, 0, 1, M_ALL, MREQ | IRW | PCW,   "lw_fetch");
      cyc(I_LW, 0, 1, M_EN,  15'h0,              "lw_decode");
      cyc(I_LW, 0, 1, M_ALL, ASR,                "lw_exec");
      cyc(I_LW, 0, 0, M_EN,  MREQ | ASRC,        "lw_mem_w1");
      cyc(I_LW, 0, 0, M_EN,  MREQ | ASRC,        "lw_mem_w2");
      cyc(I_LW, 0, 0, M_EN,  MREQ | ASRC,        "lw_mem_w3");
      cyc(I_LW, 0, 1, M_EN,  MREQ | ASRC,        "lw_mem_done");
      cyc(I_LW, 0, 1, M_EN,  RW | RS,            "lw_wb");

      // R-type operations
      cyc(I_SUB, 0, 1, M_ALL, MREQ | IRW | PCW,  "sub_fetch");
      cyc(I_SUB, 0, 1, M_EN,  15'h0,             "sub_decode");
      cyc(I_SUB, 0, 1, M_ALL, SUB,               "sub_exec");
      cyc(I_SUB, 0, 1, M_EN,  RW,                "sub_wb");
      cyc(I_OR,  0, 1, M_ALL, MREQ | IRW | PCW,  "or_fetch");
      cyc(I_OR,  0, 1, M_EN,  15'h0,             "or_decode");
      cyc(I_OR,  0, 1, M_ALL, OR3,               "or_exec");
      cyc(I_OR,  0, 1, M_EN,  RW,                "or_wb");
      cyc(I_SLT, 0, 1, M_ALL, MREQ | IRW | PCW,  "slt_fetch");
      cyc(I_SLT, 0, 1, M_EN,  15'h0,             "slt_decode");
      cyc(I_SLT, 0, 1, M_ALL, SLT,               "slt_exec");
      cyc(I_SLT, 0, 1, M_EN,  RW,                "slt_wb");

      // sw, zero-wait
      cyc(I_SW, 0, 1, M_ALL, MREQ | IRW | PCW,   "sw_fetch");
      cyc(I_SW, 0, 1, M_EN,  15'h0,              "sw_decode");
      cyc(I_SW, 0, 1, M_ALL, ASR | IMMS,         "sw_exec");
      cyc(I_SW, 0, 1, M_EN,  MREQ | MWE | ASRC,  "sw_mem");

      // bne taken then not taken
      cyc(I_BNE, 0, 1, M_ALL, MREQ | IRW | PCW,  "bne0_fetch");
      cyc(I_BNE, 0, 1, M_EN,  15'h0,             "bne0_decode");
      cyc(I_BNE, 0, 1, M_ALL, PCW | PCS | SUB | IMMB, "bne0_exec");
      cyc(I_BNE, 1, 1, M_ALL, MREQ | IRW | PCW,  "bne1_fetch");
      cyc(I_BNE, 1, 1, M_EN,  15'h0,             "bne1_decode");
      cyc(I_BNE, 1, 1, M_ALL, SUB | IMMB,        "bne1_exec");

      // Illegal opcode traps and holds until reset
      cyc(I_BAD, 0, 1, M_ALL, MREQ | IRW | PCW,  "ill_fetch");
      cyc(I_BAD, 0, 1, M_EN,  15'h0,             "ill_decode");
      cyc(I_BAD, 0, 1, M_EN,  ILL,               "ill_trap1");
      cyc(I_BAD, 0, 1, M_EN,  ILL,               "ill_trap2");
      cyc(I_BAD, 0, 1, M_EN,  ILL,               "ill_trap3");
      rst = 1'b0;
      cyc(I_BAD, 0, 1, M_ALL, 15'h0,             "ill_reset");
      rst = 1'b1;

      // addi, sw, bne back-to-back: 4 + 4 + 3 cycles
      cyc(I_ADDI, 0, 1, M_ALL, MREQ | IRW | PCW, "seq_addi_fetch");
      cyc(I_ADDI, 0, 1, M_EN,  15'h0,            "seq_addi_decode");
      cyc(I_ADDI, 0, 1, M_ALL, ASR,              "seq_addi_exec");
      cyc(I_ADDI, 0, 1, M_EN,  RW,               "seq_addi_wb");
      cyc(I_SW,   0, 1, M_ALL, MREQ | IRW | PCW, "seq_sw_fetch");
      cyc(I_SW,   0, 1, M_EN,  15'h0,            "seq_sw_decode");
      cyc(I_SW,   0, 1, M_ALL, ASR | IMMS,       "seq_sw_exec");
      cyc(I_SW,   0, 1, M_EN,  MREQ | MWE | ASRC, "seq_sw_mem");
      cyc(I_BNE,  0, 1, M_ALL, MREQ | IRW | PCW, "seq_bne_fetch");
      cyc(I_BNE,  0, 1, M_EN,  15'h0,            "seq_bne_decode");
      cyc(I_BNE,  0, 1, M_ALL, PCW | PCS | SUB | IMMB, "seq_bne_exec");
`ifdef MULTICYCLE_CTRL_PERF_EN
      #1;
      chk("perf_cycle", cycle_cnt, 32'd11);
      chk("perf_instret", instret_cnt, 32'd3);
`endif

      // Reset in the middle of a load's MEM wait
      cyc(I_LW, 0, 1, M_ALL, MREQ | IRW | PCW,   "mid_fetch");
      cyc(I_LW, 0, 1, M_EN,  15'h0,              "mid_decode");
      cyc(I_LW, 0, 1, M_ALL, ASR,                "mid_exec");
      cyc(I_LW, 0, 0, M_EN,  MREQ | ASRC,        "mid_mem");
      rst = 1'b0;
      cyc(I_LW, 0, 0, M_ALL, 15'h0,              "mid_rst_now");
      cyc(I_LW, 0, 1, M_ALL, 15'h0,              "mid_rst_next");
`ifdef MULTICYCLE_CTRL_PERF_EN
      chk("mid_rst_cycle", cycle_cnt, 32'd0);
      chk("mid_rst_instret", instret_cnt, 32'd0);
`endif
      rst = 1'b1;
      cyc(I_LW, 0, 0, M_ALL, MREQ,               "mid_release_fetch");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
